btog_ptr_counter: RTL and testbench
===================================

# btog_ptr_counter

Registered binary-to-Gray pointer counter: it keeps a WIDTH-bit binary count and a registered Gray-coded copy of the same value, updated on the same clock edge. It is the encode side of our Gray pointer path. The source-domain FIFO/pointer logic drives it, and its glitch-free `gray_q` crosses clock domains to a Gray-to-binary decoder in the destination domain.

## Interface
- WIDTH, 4, pointer width in bits; legal range 2..16
- clk  input  1  sole clock; all state updates on its rising edge
- rst  input  1  asynchronous, active-high reset
- clear  input  1  synchronous clear of the count to 0
- load  input  1  synchronous load of `load_bin`
- load_bin  input  WIDTH  binary value to load
- inc  input  1  increment the count by 1 (modulo 2^WIDTH)
- bin_q  output  WIDTH  registered binary count
- gray_q  output  WIDTH  registered Gray encoding of `bin_q`; safe to synchronize across domains
- gray_next  output  WIDTH  combinational Gray value `gray_q` will take on the next edge (used for full/empty compares)
- wrap  output  1  registered one-cycle pulse when an increment takes the count from 2^WIDTH-1 to 0
- step_err  output  1  registered sticky flag: a pure increment changed more than one `gray_q` bit

## Operation
- Vectors are [WIDTH-1:0]; index WIDTH-1 is the MSB.
- Encoding: `gray = bin ^ (bin >> 1)`; gray MSB equals bin MSB.
- Next-binary selection is priority-ordered: clear > load > inc > hold.
  - clear: next = 0
  - load: next = load_bin
  - inc: next = bin_q + 1, truncated to WIDTH bits
  - none: next = bin_q
- `gray_next` = encode(next binary). On each edge, `gray_q` <= `gray_next`.
- `gray_q` must never be encoded from `bin_q` through logic after the register. It is a flop output, so no glitches reach the synchronizer.
- `wrap` <= 1 only when the selected operation is inc and bin_q = 2^WIDTH-1. Otherwise it is 0, including for clear/load to 0.
- `step_err` sets when the selected operation is inc and popcount(gray_q ^ gray_next) != 1. It clears only on rst. Load and clear may legally change several bits and never set it.
- Simultaneous inc + load: load wins and inc is dropped, with no wrap.
- Simultaneous inc + clear: clear wins.

## Timing
- Reset (async assert, any time): bin_q=0, gray_q=0, wrap=0, step_err=0. `gray_next` then reflects the inputs applied to count 0.
- Reset deassertion is synchronous to clk at the integrating level. The first update happens on the first rising edge with rst low.
- Latency: a command sampled on edge N appears on bin_q, gray_q and wrap after edge N, i.e. one cycle. `gray_next` has zero latency (combinational from inputs and state).
- bin_q and gray_q always correspond: gray_q == encode(bin_q) on every cycle after reset.
- Throughput: one increment per cycle, sustained. The count wraps 2^WIDTH-1 -> 0 with gray going from 1000…0 to 0…0, a one-bit change.
- If rst asserts mid-increment, the in-flight update is discarded and all outputs take their reset values immediately.

## Structure
- Package `gray_pkg`:
  - function `bin2gray(WIDTH)`
  - function `gray2bin(WIDTH)`, used by the bench and assertions
  - localparam `GRAY_W_DEFAULT = 4`
- Sub-module `btog_enc`: purely combinational WIDTH-bit binary-to-Gray encoder. It is instantiated once on the next-binary value to produce `gray_next`.
- Top level holds the priority mux, the bin/gray/wrap/step_err flops and the popcount check.

## Test plan
- Reset: assert rst mid-run at count 9 -> bin_q=0, gray_q=0000, wrap=0, step_err=0 immediately, without waiting for a clock edge.
- Full sweep, WIDTH=4: 20 consecutive inc cycles from 0 -> gray_q sequence 0000,0001,0011,0010,0110,…,1000 then 0000. There is exactly one bit change per step, wrap pulses once on the 15->0 edge, and step_err stays 0.
- Load: load_bin=4'b1011 -> next cycle bin_q=1011, gray_q=1110, wrap=0. A subsequent inc gives bin_q=1100, gray_q=1010.
- Priority: clear+load+inc together at count 5 -> bin_q=0, gray_q=0000. Load(3)+inc together -> bin_q=0011, gray_q=0010.
- Wrap only on increment: load 15, then clear -> wrap stays 0. Load 15, then inc -> wrap=1 for exactly one cycle.
- Decode cross-check: random inc/load/clear for 10k cycles -> gray2bin(gray_q)==bin_q every cycle, and gray_next on cycle N equals gray_q on cycle N+1.

Source files
------------

// File: rtl/gray_pkg.sv
// gray_pkg: shared definitions for the Gray pointer path.
//   - GRAY_W_DEFAULT / GRAY_W_MAX : default and largest supported pointer width
//   - ptr_op_e                    : operation selected for the pointer this cycle
//   - bin2gray / gray2bin         : width-agnostic converters; callers zero-extend
//                                   narrower vectors to GRAY_W_MAX bits, which
//                                   leaves the low WIDTH bits of the result exact
//   - popcount                    : number of set bits in a GRAY_W_MAX vector
package gray_pkg;

  localparam int GRAY_W_DEFAULT = 4;
  localparam int GRAY_W_MAX     = 16;
  localparam int POPCNT_W       = 5;

  typedef enum logic [1:0] {
    OP_HOLD  = 2'd0,
    OP_INC   = 2'd1,
    OP_LOAD  = 2'd2,
    OP_CLEAR = 2'd3
  } ptr_op_e;

  function automatic logic [GRAY_W_MAX-1:0] bin2gray(input logic [GRAY_W_MAX-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Each binary bit is the XOR of all Gray bits at or above it.
  function automatic logic [GRAY_W_MAX-1:0] gray2bin(input logic [GRAY_W_MAX-1:0] g);
    logic [GRAY_W_MAX-1:0] b;
    b[GRAY_W_MAX-1] = g[GRAY_W_MAX-1];
    for (int i = GRAY_W_MAX - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  function automatic logic [POPCNT_W-1:0] popcount(input logic [GRAY_W_MAX-1:0] v);
    logic [POPCNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < GRAY_W_MAX; i++) begin
      c = c + {{(POPCNT_W-1){1'b0}}, v[i]};
    end
    return c;
  endfunction

endpackage

// File: rtl/btog_enc.sv
// btog_enc: purely combinational WIDTH-bit binary-to-Gray encoder.
//   bin_i  : binary input
//   gray_o : Gray encoding of bin_i (gray MSB equals binary MSB)
module btog_enc #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] bin_i,
  output logic [WIDTH-1:0] gray_o
);

  assign gray_o = bin_i ^ (bin_i >> 1);

endmodule

// File: rtl/btog_ptr_counter.sv
// btog_ptr_counter: registered binary count plus a registered Gray copy of the
// same value, both updated on the same edge. gray_q comes straight off a flop so
// it is glitch-free and may be synchronized into another clock domain.
//   clk       : clock, all updates on the rising edge
//   rst       : asynchronous active-high reset
//   clear     : synchronous clear to 0 (highest priority)
//   load      : synchronous load of load_bin
//   load_bin  : value to load
//   inc       : increment modulo 2^WIDTH (lowest priority)
//   bin_q     : registered binary count
//   gray_q    : registered Gray encoding of bin_q
//   gray_next : combinational Gray value gray_q takes on the next edge
//   wrap      : one-cycle pulse after an increment from all-ones to 0
//   step_err  : sticky flag, an increment changed other than exactly one Gray bit
import gray_pkg::*;

module btog_ptr_counter #(
  parameter int WIDTH = GRAY_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_bin,
  input  logic             inc,
  output logic [WIDTH-1:0] bin_q,
  output logic [WIDTH-1:0] gray_q,
  output logic [WIDTH-1:0] gray_next,
  output logic             wrap,
  output logic             step_err
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  ptr_op_e               op;
  logic [WIDTH-1:0]      bin_d;
  logic [WIDTH-1:0]      gray_d;
  logic                  wrap_d;
  logic                  wrap_q;
  logic                  step_err_d;
  logic                  step_err_q;
  logic [GRAY_W_MAX-1:0] gray_diff;
  logic [POPCNT_W-1:0]   gray_diff_cnt;
  logic                  step_bad;

  // Priority: clear > load > inc > hold. A dropped inc never wraps.
  always_comb begin
    op = OP_HOLD;
    if (clear) begin
      op = OP_CLEAR;
    end else if (load) begin
      op = OP_LOAD;
    end else if (inc) begin
      op = OP_INC;
    end
  end

  always_comb begin
    bin_d = bin_q;
    case (op)
      OP_CLEAR: bin_d = '0;
      OP_LOAD:  bin_d = load_bin;
      OP_INC:   bin_d = bin_q + ONE;
      default:  bin_d = bin_q;
    endcase
  end

  // The Gray register is fed from the encoded next-binary value, never from
  // bin_q after its flop, so gray_q itself has no combinational path.
  btog_enc #(
    .WIDTH (WIDTH)
  ) u_enc (
    .bin_i  (bin_d),
    .gray_o (gray_d)
  );

  assign gray_next = gray_d;

  always_comb begin
    gray_diff              = '0;
    gray_diff[WIDTH-1:0]   = gray_q ^ gray_d;
  end

  assign gray_diff_cnt = popcount(gray_diff);

  // Only increments are required to be single-bit steps; load/clear may jump.
  assign step_bad   = (op == OP_INC) && (gray_diff_cnt != POPCNT_W'(1));
  assign step_err_d = step_err_q | step_bad;
  assign wrap_d     = (op == OP_INC) && (bin_q == '1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bin_q      <= '0;
      gray_q     <= '0;
      wrap_q     <= 1'b0;
      step_err_q <= 1'b0;
    end else begin
      bin_q      <= bin_d;
      gray_q     <= gray_d;
      wrap_q     <= wrap_d;
      step_err_q <= step_err_d;
    end
  end

  assign wrap     = wrap_q;
  assign step_err = step_err_q;

endmodule

// File: tb/tb_btog_ptr_counter.sv
module tb_btog_ptr_counter;
  import gray_pkg::*;

  logic       clk;
  logic       rst;
  logic       clear;
  logic       load;
  logic [3:0] load_bin;
  logic       inc;
  logic [3:0] bin_q;
  logic [3:0] gray_q;
  logic [3:0] gray_next;
  logic       wrap;
  logic       step_err;

  int checks = 0;
  int errors = 0;

  // Hand-written 4-bit Gray sequence for counts 0..15.
  logic [3:0] gray_tab [16] = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                                4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};

  btog_ptr_counter #(.WIDTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear),
    .load      (load),
    .load_bin  (load_bin),
    .inc       (inc),
    .bin_q     (bin_q),
    .gray_q    (gray_q),
    .gray_next (gray_next),
    .wrap      (wrap),
    .step_err  (step_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [3:0]  prev_gray;
  logic [3:0]  m;
  logic [3:0]  m_next;
  logic [3:0]  gn;
  logic        c_r, l_r, i_r;
  logic        exp_wrap;
  logic [15:0] dec;
  int          wrap_cnt;

  initial begin
    rst = 1'b1; clear = 1'b0; load = 1'b0; inc = 1'b0; load_bin = 4'h0;
    repeat (2) tick();
    check("rst_bin",   16'(bin_q), 16'h0);
    check("rst_gray",  16'(gray_q), 16'h0);
    check("rst_wrap",  16'(wrap), 16'h0);
    check("rst_err",   16'(step_err), 16'h0);
    check("rst_gnext", 16'(gray_next), 16'h0);
    inc = 1'b1;
    #1;
    check("rst_gnext_inc", 16'(gray_next), 16'h1);
    rst = 1'b0;

    // Sweep: 20 increments from 0.
    prev_gray = 4'h0;
    wrap_cnt  = 0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      check("sweep_bin",  16'(bin_q), 16'(k % 16));
      check("sweep_gray", 16'(gray_q), 16'(gray_tab[k % 16]));
      check("sweep_1bit", 16'($countones(gray_q ^ prev_gray)), 16'h1);
      check("sweep_wrap", 16'(wrap), (k == 16) ? 16'h1 : 16'h0);
      check("sweep_err",  16'(step_err), 16'h0);
      if (wrap) wrap_cnt++;
      prev_gray = gray_q;
    end
    check("sweep_wrap_cnt", 16'(wrap_cnt), 16'h1);

    // Load then increment.
    inc = 1'b0; load = 1'b1; load_bin = 4'hB;
    tick();
    check("load_bin",  16'(bin_q), 16'hB);
    check("load_gray", 16'(gray_q), 16'hE);
    check("load_wrap", 16'(wrap), 16'h0);
    load = 1'b0; inc = 1'b1;
    tick();
    check("load_inc_bin",  16'(bin_q), 16'hC);
    check("load_inc_gray", 16'(gray_q), 16'hA);

    // Priority: clear + load + inc at count 5.
    inc = 1'b0; load = 1'b1; load_bin = 4'h5;
    tick();
    check("pri_pre_bin", 16'(bin_q), 16'h5);
    clear = 1'b1; load_bin = 4'h9; inc = 1'b1;
    tick();
    check("pri_clr_bin",  16'(bin_q), 16'h0);
    check("pri_clr_gray", 16'(gray_q), 16'h0);
    // load(3) + inc
    clear = 1'b0; load_bin = 4'h3;
    #1;
    check("pri_ld_gnext", 16'(gray_next), 16'h2);
    tick();
    check("pri_ld_bin",  16'(bin_q), 16'h3);
    check("pri_ld_gray", 16'(gray_q), 16'h2);
    check("pri_ld_wrap", 16'(wrap), 16'h0);

    // Wrap only on increment.
    inc = 1'b0; load_bin = 4'hF;
    tick();
    check("wr_ld15_bin", 16'(bin_q), 16'hF);
    load = 1'b0; clear = 1'b1;
    tick();
    check("wr_clr_bin",  16'(bin_q), 16'h0);
    check("wr_clr_wrap", 16'(wrap), 16'h0);
    clear = 1'b0; load = 1'b1;
    tick();
    check("wr_ld15b_gray", 16'(gray_q), 16'h8);
    load = 1'b0; inc = 1'b1;
    tick();
    check("wr_inc_bin",  16'(bin_q), 16'h0);
    check("wr_inc_gray", 16'(gray_q), 16'h0);
    check("wr_inc_wrap", 16'(wrap), 16'h1);
    inc = 1'b0;
    tick();
    check("wr_hold_wrap", 16'(wrap), 16'h0);
    load = 1'b1;
    tick();
    inc = 1'b1;
    tick();
    check("wr_ldinc_bin",  16'(bin_q), 16'hF);
    check("wr_ldinc_wrap", 16'(wrap), 16'h0);
    check("wr_err",        16'(step_err), 16'h0);

    // Asynchronous reset mid-run at count 9.
    inc = 1'b0; load_bin = 4'h9;
    tick();
    check("ar_pre_bin",  16'(bin_q), 16'h9);
    check("ar_pre_gray", 16'(gray_q), 16'hD);
    load = 1'b0; inc = 1'b1;
    #3;
    rst = 1'b1;
    #1;
    check("ar_bin",   16'(bin_q), 16'h0);
    check("ar_gray",  16'(gray_q), 16'h0);
    check("ar_wrap",  16'(wrap), 16'h0);
    check("ar_err",   16'(step_err), 16'h0);
    check("ar_gnext", 16'(gray_next), 16'h1);
    tick();
    check("ar_hold_bin", 16'(bin_q), 16'h0);
    rst = 1'b0; inc = 1'b0;

    // Random cross-check against an independent model.
    m = 4'h0;
    for (int n = 0; n < 10000; n++) begin
      c_r = ($urandom_range(0, 15) == 0);
      l_r = ($urandom_range(0, 7) == 0);
      i_r = ($urandom_range(0, 3) != 0);
      clear = c_r; load = l_r; inc = i_r;
      load_bin = 4'($urandom_range(0, 15));
      if (c_r)      m_next = 4'h0;
      else if (l_r) m_next = load_bin;
      else if (i_r) m_next = m + 4'h1;
      else          m_next = m;
      exp_wrap = !c_r && !l_r && i_r && (m == 4'hF);
      #1;
      gn = gray_next;
      tick();
      check("rnd_bin",   16'(bin_q), 16'(m_next));
      check("rnd_gnext", 16'(gray_q), 16'(gn));
      dec = gray2bin({12'h000, gray_q});
      check("rnd_dec",   dec, 16'(bin_q));
      check("rnd_wrap",  16'(wrap), 16'(exp_wrap));
      m = m_next;
    end
    clear = 1'b0; load = 1'b0; inc = 1'b0;
    check("rnd_err", 16'(step_err), 16'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
